// File: rtl/distance_bcd.sv
// distance_bcd
// Sequential binary-to-BCD converter for the averaged distance value.
// It uses shift-and-add-3 (double dabble) and processes one input bit per clock.
// It also produces a leading-zero blanking mask for the seven-segment driver.
//
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high reset
//   start  - request conversion of din (honoured only when idle)
//   din    - unsigned binary distance, WIDTH bits
//   busy   - high while a conversion is in progress
//   done   - one-cycle pulse when bcd/blank have just been updated
//   bcd    - DIGITS packed BCD digits, digit 0 (ones) in bits [3:0]
//   blank  - blank[k]=1 marks digit k as a leading zero (never set for digit 0)
module distance_bcd #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      din,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    // Compute 10**n in a wide integer so the range check also works
    // for large WIDTH values.
    function automatic logic [127:0] pow10(input int n);
        logic [127:0] r;
        r = 128'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 128'd10;
        end
        return r;
    endfunction

    generate
        if (pow10(DIGITS) <= ((128'd1 << WIDTH) - 128'd1)) begin : g_bad_digits
            $error("distance_bcd: DIGITS too small to hold 2**WIDTH-1");
        end
    endgenerate

    typedef enum logic [0:0] {IDLE, SHIFT} state_t;

    state_t                 state_reg, state_next;
    logic [WIDTH-1:0]       bin_reg, bin_next;
    logic [4*DIGITS-1:0]    scratch_reg, scratch_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [4*DIGITS-1:0]    bcd_reg, bcd_next;
    logic [DIGITS-1:0]      blank_reg, blank_next;
    logic                   done_reg, done_next;

    // Datapath for one iteration.
    // First apply the add-3 correction to every nibble in parallel.
    // Then shift {scratch, binary} left by one bit.
    logic [4*DIGITS-1:0]        corrected;
    logic [4*DIGITS+WIDTH-1:0]  shifted;
    logic [4*DIGITS-1:0]        scratch_shift;
    logic [WIDTH-1:0]           bin_shift;
    logic [DIGITS-1:0]          blank_calc;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_nibble
            // 4-bit add with no carry into the next nibble.
            // A nibble >= 5 can only reach 12 here, so it never overflows.
            assign corrected[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                                        ? scratch_reg[4*gi +: 4] + 4'd3
                                        : scratch_reg[4*gi +: 4];
        end
    endgenerate

    assign shifted       = {corrected, bin_reg} << 1;
    assign scratch_shift = shifted[4*DIGITS+WIDTH-1:WIDTH];
    assign bin_shift     = shifted[WIDTH-1:0];

    // Leading-zero mask for the value being loaded into bcd.
    // Digit k is blank when it and every higher digit are zero.
    // The ones digit is always lit.
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_blank
            if (gi == 0) begin : g_ones
                assign blank_calc[gi] = 1'b0;
            end else begin : g_upper
                assign blank_calc[gi] = ~|scratch_shift[4*DIGITS-1:4*gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            bin_reg     <= '0;
            scratch_reg <= '0;
            cnt_reg     <= '0;
            bcd_reg     <= '0;
            blank_reg   <= BLANK_RST;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bin_reg     <= bin_next;
            scratch_reg <= scratch_next;
            cnt_reg     <= cnt_next;
            bcd_reg     <= bcd_next;
            blank_reg   <= blank_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bin_next     = bin_reg;
        scratch_next = scratch_reg;
        cnt_next     = cnt_reg;
        bcd_next     = bcd_reg;
        blank_next   = blank_reg;
        done_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    bin_next     = din;
                    scratch_next = '0;
                    cnt_next     = '0;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                bin_next     = bin_shift;
                scratch_next = scratch_shift;
                cnt_next     = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    // Last bit shifted in.
                    // Publish the result and blank mask together.
                    bcd_next   = scratch_shift;
                    blank_next = blank_calc;
                    done_next  = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy  = (state_reg == SHIFT);
    assign done  = done_reg;
    assign bcd   = bcd_reg;
    assign blank = blank_reg;

endmodule

// File: tb/tb_distance_bcd.sv
// Directed testbench for distance_bcd with default parameters (WIDTH=16, DIGITS=5).
module tb_distance_bcd;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] din;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic [4:0]  blank;

    int checks_total;
    int checks_passed;

    distance_bcd #(.WIDTH(16), .DIGITS(5)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .blank (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Convert one value with a single-cycle start pulse.
    // Check the latency, the busy length, the result and the done pulse width.
    task automatic run_conv(input logic [15:0] value, input logic [19:0] exp_bcd,
                            input logic [4:0] exp_blank);
        int cycles;
        int busy_cnt;
        @(negedge clk);
        reset = 1'b0;
        din   = value;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("busy_on_accept", {31'd0, busy}, 32'd1);
        cycles   = 0;
        busy_cnt = 1;
        while (!done && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
            if (busy) busy_cnt++;
        end
        check_eq("latency", cycles, 32'd16);
        check_eq("busy_len", busy_cnt, 32'd16);
        check_eq("busy_at_done", {31'd0, busy}, 32'd0);
        check_eq("bcd", {12'd0, bcd}, {12'd0, exp_bcd});
        check_eq("blank", {27'd0, blank}, {27'd0, exp_blank});
        @(posedge clk);
        #1;
        check_eq("done_pulse_width", {31'd0, done}, 32'd0);
        $display("conv din=%0d bcd=0x%05h blank=%05b latency=%0d", value, bcd, blank, cycles);
    endtask

    initial begin
        int cycles;
        int done_cnt;
        int gap_bad;
        logic [15:0] vals [3];
        logic [19:0] exps [3];

        checks_total  = 0;
        checks_passed = 0;
        reset = 1'b1;
        start = 1'b0;
        din   = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_bcd", {12'd0, bcd}, 32'd0);
        check_eq("rst_blank", {27'd0, blank}, 32'b11110);
        $display("reset state busy=%0b done=%0b bcd=0x%05h blank=%05b", busy, done, bcd, blank);

        // Basic values, including the full-scale boundary.
        run_conv(16'd0,     20'h00000, 5'b11110);
        run_conv(16'd65535, 20'h65535, 5'b00000);
        run_conv(16'd1234,  20'h01234, 5'b10000);
        run_conv(16'd9,     20'h00009, 5'b11110);
        run_conv(16'd100,   20'h00100, 5'b11000);

        // A start while busy is ignored, and a din change mid-conversion has no effect.
        @(negedge clk);
        din   = 16'd500;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        din   = 16'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cycles   = 6;
        done_cnt = 0;
        while (!done && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (done) done_cnt++;
        check_eq("ign_latency", cycles, 32'd16);
        check_eq("ign_bcd", {12'd0, bcd}, 32'h00500);
        check_eq("ign_blank", {27'd0, blank}, 32'b11000);
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check_eq("ign_done_count", done_cnt, 32'd1);
        check_eq("ign_idle_busy", {31'd0, busy}, 32'd0);
        $display("ignored-start din=500 bcd=0x%05h dones=%0d", bcd, done_cnt);

        // Start held high.
        // Conversions should complete every 17 cycles with no idle gap.
        vals[0] = 16'd10; vals[1] = 16'd20; vals[2] = 16'd30;
        exps[0] = 20'h00010; exps[1] = 20'h00020; exps[2] = 20'h00030;
        @(negedge clk);
        din   = vals[0];
        start = 1'b1;
        @(posedge clk);
        #1;
        gap_bad = 0;
        for (int k = 0; k < 3; k++) begin
            cycles = 0;
            do begin
                @(posedge clk);
                #1;
                cycles++;
                if (!busy && !done) gap_bad++;
            end while (!done && cycles < 40);
            check_eq((k == 0) ? "hold_latency0" : "hold_period", cycles, (k == 0) ? 32'd16 : 32'd17);
            check_eq("hold_bcd", {12'd0, bcd}, {12'd0, exps[k]});
            $display("held-start conv %0d bcd=0x%05h cycles=%0d", k, bcd, cycles);
            if (k < 2) din = vals[k+1];
            else       start = 1'b0;
        end
        check_eq("hold_no_gap", gap_bad, 32'd0);

        // Reset in the middle of a conversion.
        @(negedge clk);
        din   = 16'd4321;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("mid_rst_done", {31'd0, done}, 32'd0);
        check_eq("mid_rst_bcd", {12'd0, bcd}, 32'd0);
        check_eq("mid_rst_blank", {27'd0, blank}, 32'b11110);
        $display("mid-conversion reset bcd=0x%05h blank=%05b", bcd, blank);
        run_conv(16'd4321, 20'h04321, 5'b10000);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/distance_bcd.md
# distance_bcd

Sequential binary-to-BCD converter for the measured distance value. It sits directly downstream of the PWM distance measurement/averaging stage and feeds the seven-segment display driver. It uses shift-and-add-3 (double dabble), one bit per clock, with a start/busy/done handshake, and produces a leading-zero blanking mask for the display.

## Interface

- WIDTH, 16, binary input width in bits.
- DIGITS, 5, number of BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH − 1; a violating combination is an elaboration error.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset. Clock is clk.
- start  input  1  request a conversion of din. Honoured only in IDLE.
- din  input  WIDTH  unsigned binary distance, normally driven by the averaged distance output.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd/blank have just been updated.
- bcd  output  4*DIGITS  result. Digit 0 (ones) is in bits [3:0], digit k is in bits [4k+3:4k].
- blank  output  DIGITS  blank[k]=1 means digit k is a leading zero and must not be lit.

## Operation

- States: IDLE and SHIFT.
- In IDLE with start=1:
  - Latch din into the binary shift register.
  - Clear the BCD scratch register and set the iteration counter to 0.
  - Go to SHIFT.
- In IDLE with start=0: hold.
- In SHIFT, one iteration per clock:
  - Every scratch nibble ≥ 5 gets +3. The corrections apply to all nibbles in parallel, in the same cycle.
  - Then shift {scratch, binary} left by one. The binary MSB enters the scratch LSB.
  - Increment the counter.
- On the iteration with counter = WIDTH−1:
  - Load the final scratch value (after this iteration's correction and shift) into bcd.
  - Compute blank from that value and pulse done.
  - Return to IDLE.
- Nibble correction is 4-bit arithmetic with no carry between nibbles. A correct implementation never yields a nibble > 9 after a shift.
- blank rules:
  - blank[0] is always 0.
  - For k ≥ 1, blank[k] = 1 iff digits k through DIGITS−1 are all zero.
  - blank is registered together with bcd, never derived from scratch.
- din is sampled only on the accepting edge. Changes to din during SHIFT have no effect.
- start while busy=1 is ignored. It is not queued.
- bcd and blank hold their last completed values until the next completion. They never show partial results.

## Timing

- Reset values:
  - State IDLE, busy=0, done=0.
  - bcd=0.
  - blank = all ones except bit 0 (5'b11110 by default).
  - Scratch and counter cleared.
- Reset mid-conversion: the conversion is aborted, all outputs take their reset values on that edge, and no done is issued. A start on the first cycle after reset deasserts is accepted.
- Accept: start=1 in IDLE at edge N, so busy=1 from edge N.
- Iterations occur at edges N+1 … N+WIDTH.
- Completion at edge N+WIDTH:
  - bcd and blank are updated.
  - done=1 for exactly one cycle.
  - busy=0 in that same cycle.
- Latency from accepting edge to done is WIDTH cycles (16 by default).
- Back-to-back: start=1 during the done cycle is accepted at the next edge. Maximum throughput is one conversion per WIDTH+1 cycles.
- start held high continuously re-triggers a conversion every WIDTH+1 cycles.

## Test plan

- Reset, then din=0 with a start pulse → done 16 cycles after the accepting edge; bcd=0x00000, blank=5'b11110.
- din=65535 → bcd=0x65535, blank=5'b00000; busy high for exactly 16 cycles.
- din=1234, then din=9, then din=100, each converted in turn → bcd=0x01234 / blank=10000; bcd=0x00009 / blank=11110; bcd=0x00100 / blank=11000.
- Start with din=500, change din to 7 and pulse start again at cycle 5 → the second start is ignored; result bcd=0x00500; exactly one done pulse.
- start held high with din stepping 10, 20, 30 at each done → conversions complete every 17 cycles with results 0x00010, 0x00020, 0x00030; no cycle with both busy=0 and done=0.
- Assert reset at cycle 8 of a din=4321 conversion → no done pulse; bcd=0, blank=11110. A new start right after reset gives bcd=0x04321 16 cycles later.
